// File: rtl/dcache_pkg.sv
// Shared types, constants and helpers for the direct-mapped data cache.
// Contents:
//   dcache_state_t   - controller state encoding
//   DC_LINE_BEATS    - beats per line (default geometry)
//   DC_OFF_BITS      - byte-offset bits of the line (default geometry)
//   DC_IDX_BITS      - set-index bits (default geometry)
//   wstrb_from_wlen  - byte-enable mask for a store of 2**wlen bytes at off
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL,
    WR_REQ,
    WR_ACK,
    RESP
  } dcache_state_t;

  localparam int unsigned DC_LINE_BEATS = 8;
  localparam int unsigned DC_OFF_BITS   = 6;
  localparam int unsigned DC_IDX_BITS   = 6;

  // Bytes that would spill past the doubleword are simply dropped.
  function automatic logic [7:0] wstrb_from_wlen(input logic [1:0] wlen,
                                                 input logic [2:0] off);
    logic [15:0] m;
    m = 16'd1 << (4'd1 << wlen);
    m = m - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the direct-mapped data cache.
// Ports:
//   clk, reset            - clock, async active-high reset (clears valid bits)
//   rd_idx, rd_beat       - read port select (combinational read)
//   rd_data/rd_tag/rd_valid - selected doubleword, line tag and valid bit
//   wr_en/wr_idx/wr_beat  - byte-masked data write port
//   wr_data/wr_strb       - write data and byte enables
//   tag_we/tag_idx/tag_data - line install: write tag and set valid
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = 2**DC_IDX_BITS,
  parameter int unsigned LINE_BEATS = DC_LINE_BEATS,
  parameter int unsigned TAG_BITS   = 52,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned IDX_BITS  = $clog2(NUM_SETS),
  localparam int unsigned BEAT_BITS = $clog2(LINE_BEATS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IDX_BITS-1:0]     rd_idx,
  input  logic [BEAT_BITS-1:0]    rd_beat,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [TAG_BITS-1:0]     rd_tag,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [IDX_BITS-1:0]     wr_idx,
  input  logic [BEAT_BITS-1:0]    wr_beat,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    tag_we,
  input  logic [IDX_BITS-1:0]     tag_idx,
  input  logic [TAG_BITS-1:0]     tag_data
);

  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS*LINE_BEATS];
  logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0]   valid_q;

  assign rd_data  = data_mem[{rd_idx, rd_beat}];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) data_mem[{wr_idx, wr_beat}][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[tag_idx] <= tag_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       valid_q          <= '0;
    else if (tag_we) valid_q[tag_idx] <= 1'b1;
  end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Serves the MEM-stage dc_* interface; misses fetch whole lines and every
// store is written through as a single masked beat on the mem_* port.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   dc_en/dc_in_addr/dc_write_en/dc_in_wdata/dc_in_wlen - request
//   dc_out_rdata                - aligned doubleword containing the address
//   dc_out_rvalid/dc_out_write_done - load / store complete
//   mem_req_*                   - memory request (line read or masked write)
//   mem_resp_valid/data/last    - read beats (ascending) or write ack
// Optional: define DCACHE_STATS_EN to add saturating stat_hits,
//   stat_misses and stat_stores counters.
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_SETS   = 2**DC_IDX_BITS,
  parameter int unsigned LINE_BYTES = 2**DC_OFF_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dc_en,
  input  logic [ADDR_WIDTH-1:0]   dc_in_addr,
  input  logic                    dc_write_en,
  input  logic [DATA_WIDTH-1:0]   dc_in_wdata,
  input  logic [1:0]              dc_in_wlen,
  output logic [DATA_WIDTH-1:0]   dc_out_rdata,
  output logic                    dc_out_rvalid,
  output logic                    dc_out_write_done,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  input  logic                    mem_resp_last
`ifdef DCACHE_STATS_EN
  ,
  output logic [63:0]             stat_hits,
  output logic [63:0]             stat_misses,
  output logic [63:0]             stat_stores
`endif
);

  localparam int unsigned OFF_BITS   = $clog2(LINE_BYTES);
  localparam int unsigned IDX_BITS   = $clog2(NUM_SETS);
  localparam int unsigned TAG_BITS   = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int unsigned LINE_BEATS = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int unsigned BEAT_BITS  = $clog2(LINE_BEATS);
  localparam int unsigned BYTE_BITS  = $clog2(DATA_WIDTH / 8);

  dcache_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_write_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [1:0]            req_wlen_q;
  logic [BEAT_BITS-1:0]  beat_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IDX_BITS-1:0]   req_idx;
  logic [BEAT_BITS-1:0]  req_beat;
  logic [TAG_BITS-1:0]   req_tag;
  logic [2:0]            req_off;
  logic [7:0]            st_strb;
  logic [DATA_WIDTH-1:0] st_data;

  assign req_idx  = req_addr_q[OFF_BITS +: IDX_BITS];
  assign req_beat = req_addr_q[BYTE_BITS +: BEAT_BITS];
  assign req_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_off  = req_addr_q[2:0];
  assign st_strb  = wstrb_from_wlen(req_wlen_q, req_off);
  assign st_data  = req_wdata_q << {req_off, 3'b000};

  logic [DATA_WIDTH-1:0]   arr_rd_data;
  logic [TAG_BITS-1:0]     arr_rd_tag;
  logic                    arr_rd_valid;
  logic                    arr_we;
  logic [BEAT_BITS-1:0]    arr_beat;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  logic [DATA_WIDTH/8-1:0] arr_wstrb;
  logic                    tag_we;
  logic                    hit;

  assign hit = arr_rd_valid && (arr_rd_tag == req_tag);

  dcache_array #(
    .NUM_SETS   (NUM_SETS),
    .LINE_BEATS (LINE_BEATS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (req_idx),
    .rd_beat  (req_beat),
    .rd_data  (arr_rd_data),
    .rd_tag   (arr_rd_tag),
    .rd_valid (arr_rd_valid),
    .wr_en    (arr_we),
    .wr_idx   (req_idx),
    .wr_beat  (arr_beat),
    .wr_data  (arr_wdata),
    .wr_strb  (arr_wstrb),
    .tag_we   (tag_we),
    .tag_idx  (req_idx),
    .tag_data (req_tag)
  );

  // A stalled MEM stage keeps presenting the finished request; it only
  // counts as new once any field differs (store data only matters for stores).
  logic same_req;
  assign same_req = dc_en && (dc_in_addr == req_addr_q) && (dc_write_en == req_write_q) &&
                    (!req_write_q || ((dc_in_wdata == req_wdata_q) && (dc_in_wlen == req_wlen_q)));

  logic latch_req, cap_hit, cap_fill, beat_clr, beat_inc;

  always_comb begin
    state_d           = state_q;
    latch_req         = 1'b0;
    cap_hit           = 1'b0;
    cap_fill          = 1'b0;
    beat_clr          = 1'b0;
    beat_inc          = 1'b0;
    arr_we            = 1'b0;
    arr_beat          = req_beat;
    arr_wdata         = st_data;
    arr_wstrb         = st_strb;
    tag_we            = 1'b0;
    mem_req_valid     = 1'b0;
    mem_req_write     = 1'b0;
    mem_req_addr      = '0;
    mem_req_wdata     = '0;
    mem_req_wstrb     = '0;
    dc_out_rvalid     = 1'b0;
    dc_out_write_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dc_en) begin
          latch_req = 1'b1;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_write_q) begin
          arr_we  = hit;
          state_d = WR_REQ;
        end else if (hit) begin
          cap_hit = 1'b1;
          state_d = RESP;
        end else begin
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr_q[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
        if (mem_req_ready) begin
          beat_clr = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (mem_resp_valid) begin
          arr_we    = 1'b1;
          arr_beat  = beat_cnt_q;
          arr_wdata = mem_resp_data;
          arr_wstrb = '1;
          beat_inc  = 1'b1;
          cap_fill  = (beat_cnt_q == req_beat);
          if (mem_resp_last) begin
            tag_we  = 1'b1;
            state_d = RESP;
          end
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {req_addr_q[ADDR_WIDTH-1:BYTE_BITS], {BYTE_BITS{1'b0}}};
        mem_req_wdata = st_data;
        mem_req_wstrb = st_strb;
        if (mem_req_ready) state_d = WR_ACK;
      end
      WR_ACK: begin
        if (mem_resp_valid) state_d = RESP;
      end
      RESP: begin
        if (same_req) begin
          dc_out_rvalid     = !req_write_q;
          dc_out_write_done = req_write_q;
        end else if (dc_en) begin
          latch_req = 1'b1;
          state_d   = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      req_wlen_q  <= '0;
      beat_cnt_q  <= '0;
      rdata_q     <= '0;
    end else begin
      if (latch_req) begin
        req_addr_q  <= dc_in_addr;
        req_write_q <= dc_write_en;
        req_wdata_q <= dc_in_wdata;
        req_wlen_q  <= dc_in_wlen;
      end
      if (beat_clr)      beat_cnt_q <= '0;
      else if (beat_inc) beat_cnt_q <= beat_cnt_q + 1'b1;
      if (cap_hit)       rdata_q <= arr_rd_data;
      else if (cap_fill) rdata_q <= mem_resp_data;
    end
  end

  assign dc_out_rdata = rdata_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && req_write_q &&
        ({1'b0, req_off} + (4'd1 << req_wlen_q)) > 4'd8)
      $error("dcache_direct: misaligned store addr=0x%0h wlen=%0d", req_addr_q, req_wlen_q);
  end
`endif

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_stores <= '0;
    end else if (state_q == LOOKUP) begin
      if (req_write_q) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 64'd1;
      end else if (hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 64'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
module tb_dcache_direct;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dc_en = 1'b0;
  logic [63:0] dc_in_addr = '0;
  logic        dc_write_en = 1'b0;
  logic [63:0] dc_in_wdata = '0;
  logic [1:0]  dc_in_wlen = '0;
  logic [63:0] dc_out_rdata;
  logic        dc_out_rvalid;
  logic        dc_out_write_done;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        mem_resp_last = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [63:0] stat_hits, stat_misses, stat_stores;
`endif

  dcache_direct dut (
    .clk               (clk),
    .reset             (rst),
    .dc_en             (dc_en),
    .dc_in_addr        (dc_in_addr),
    .dc_write_en       (dc_write_en),
    .dc_in_wdata       (dc_in_wdata),
    .dc_in_wlen        (dc_in_wlen),
    .dc_out_rdata      (dc_out_rdata),
    .dc_out_rvalid     (dc_out_rvalid),
    .dc_out_write_done (dc_out_write_done),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_write     (mem_req_write),
    .mem_req_addr      (mem_req_addr),
    .mem_req_wdata     (mem_req_wdata),
    .mem_req_wstrb     (mem_req_wstrb),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .mem_resp_last     (mem_resp_last)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits         (stat_hits),
    .stat_misses       (stat_misses),
    .stat_stores       (stat_stores)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Backing memory: sparse store, untouched doublewords read a pattern of their address.
  logic [63:0] mem [logic [63:0]];

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {32'hC0DE0000, a[31:0]};
  endfunction

  int          m_rd_cnt = 0;
  int          m_wr_cnt = 0;
  int          m_k = 0;
  bit          m_busy = 0;
  bit          m_wr = 0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_cur;
  logic [63:0] last_rd_addr = '0;
  logic [63:0] last_wr_addr = '0;
  logic [63:0] last_wdata = '0;
  logic [7:0]  last_wstrb = '0;

  always @(negedge clk) begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_last  = 1'b0;
    mem_resp_data  = '0;
    if (rst) begin
      m_busy = 0;
      m_k    = 0;
    end else if (m_busy) begin
      mem_resp_valid = 1'b1;
      if (m_wr) begin
        mem_resp_last = 1'b1;
        m_busy = 0;
      end else begin
        mem_resp_data = mem_rd(m_addr + 64'(m_k * 8));
        m_k++;
        if (m_k == 8) begin
          mem_resp_last = 1'b1;
          m_busy = 0;
        end
      end
    end else if (mem_req_valid) begin
      mem_req_ready = 1'b1;
      m_busy = 1;
      m_k    = 0;
      m_wr   = mem_req_write;
      m_addr = mem_req_addr;
      if (mem_req_write) begin
        m_wr_cnt++;
        last_wr_addr = mem_req_addr;
        last_wdata   = mem_req_wdata;
        last_wstrb   = mem_req_wstrb;
        m_cur = mem_rd(mem_req_addr);
        for (int b = 0; b < 8; b++)
          if (mem_req_wstrb[b]) m_cur[b*8 +: 8] = mem_req_wdata[b*8 +: 8];
        mem[mem_req_addr] = m_cur;
      end else begin
        m_rd_cnt++;
        last_rd_addr = mem_req_addr;
      end
    end
  end

  task automatic do_req(input string tag, input logic [63:0] addr, input logic we,
                        input logic [63:0] wd, input logic [1:0] wl, input bit keep,
                        output logic [63:0] rd, output int lat);
    bit done;
    done = 0;
    rd   = '0;
    lat  = 0;
    @(negedge clk);
    dc_en = 1'b1; dc_in_addr = addr; dc_write_en = we; dc_in_wdata = wd; dc_in_wlen = wl;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (we ? dc_out_write_done : dc_out_rvalid) begin
        done = 1;
        rd   = dc_out_rdata;
      end
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    if (!keep) begin
      @(negedge clk);
      dc_en = 1'b0;
    end
  endtask

  logic [63:0] rd;
  int          lat;
  int          r0, w0, highs;
  bit          hit4;

  initial begin
    for (int k = 0; k < 8; k++) mem[64'h1000 + 64'(k * 8)] = 64'h11 * 64'(k + 1);

    #1;
    check("rst_rvalid", 64'(dc_out_rvalid), 64'd0);
    check("rst_wdone",  64'(dc_out_write_done), 64'd0);
    check("rst_reqv",   64'(mem_req_valid), 64'd0);
    check("rst_rdata",  dc_out_rdata, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Cold load, then a hit in the same line
    r0 = m_rd_cnt;
    do_req("cold", 64'h1000, 1'b0, '0, 2'd0, 0, rd, lat);
    check("cold_rdata", rd, 64'h11);
    check("cold_nrd", 64'(m_rd_cnt - r0), 64'd1);
    check("cold_raddr", last_rd_addr, 64'h1000);
    r0 = m_rd_cnt;
    do_req("hit", 64'h1008, 1'b0, '0, 2'd0, 0, rd, lat);
    check("hit_rdata", rd, 64'h22);
    check("hit_lat", 64'(lat), 64'd2);
    check("hit_nrd", 64'(m_rd_cnt - r0), 64'd0);

    // Byte store hit, write-through
    w0 = m_wr_cnt;
    do_req("stb", 64'h1003, 1'b1, 64'hAB, 2'd0, 0, rd, lat);
    check("stb_nwr", 64'(m_wr_cnt - w0), 64'd1);
    check("stb_addr", last_wr_addr, 64'h1000);
    check("stb_strb", 64'(last_wstrb), 64'h08);
    check("stb_wdata", last_wdata, 64'hAB00_0000);
    do_req("ldb", 64'h1000, 1'b0, '0, 2'd0, 0, rd, lat);
    check("ldb_rdata", rd, 64'hAB00_0011);
    check("ldb_lat", 64'(lat), 64'd2);

    // Word store miss: no allocate
    do_req("stw", 64'h3004, 1'b1, 64'hDEADBEEF, 2'd2, 0, rd, lat);
    check("stw_addr", last_wr_addr, 64'h3000);
    check("stw_strb", 64'(last_wstrb), 64'hF0);
    check("stw_wdata", last_wdata, 64'hDEADBEEF_0000_0000);
    r0 = m_rd_cnt;
    do_req("ldw", 64'h3000, 1'b0, '0, 2'd0, 0, rd, lat);
    check("ldw_nrd", 64'(m_rd_cnt - r0), 64'd1);
    check("ldw_rdata", rd, 64'hDEADBEEF_0000_3000);

    // Conflict: 0x1000 / 0x2000 / 0x1000 share set 0
    r0 = m_rd_cnt;
    do_req("cf1", 64'h1000, 1'b0, '0, 2'd0, 0, rd, lat);
    check("cf1_rdata", rd, 64'hAB00_0011);
    do_req("cf2", 64'h2000, 1'b0, '0, 2'd0, 0, rd, lat);
    check("cf2_rdata", rd, 64'hC0DE0000_0000_2000);
    do_req("cf3", 64'h1000, 1'b0, '0, 2'd0, 0, rd, lat);
    check("cf3_rdata", rd, 64'hAB00_0011);
    check("cf_nrd", 64'(m_rd_cnt - r0), 64'd3);

    // Held request past rvalid
    r0 = m_rd_cnt;
    highs = 0;
    do_req("held", 64'h4040, 1'b0, '0, 2'd0, 1, rd, lat);
    check("held_rdata", rd, 64'hC0DE0000_0000_4040);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (dc_out_rvalid) highs++;
    end
    @(negedge clk);
    dc_en = 1'b0;
    check("held_highs", 64'(highs), 64'd5);
    check("held_nrd", 64'(m_rd_cnt - r0), 64'd1);

    // Load then store to the same address without dropping dc_en
    do_req("at_ld", 64'h1008, 1'b0, '0, 2'd0, 1, rd, lat);
    check("at_ld_rdata", rd, 64'h22);
    do_req("at_st", 64'h1008, 1'b1, 64'h5566, 2'd1, 0, rd, lat);
    check("at_st_strb", 64'(last_wstrb), 64'h03);
    check("at_st_addr", last_wr_addr, 64'h1008);
    do_req("at_rd", 64'h1008, 1'b0, '0, 2'd0, 0, rd, lat);
    check("at_rd_rdata", rd, 64'h5566);
    check("at_rd_lat", 64'(lat), 64'd2);

    // Reset in the middle of a fill
    @(negedge clk);
    dc_en = 1'b1; dc_in_addr = 64'h1040; dc_write_en = 1'b0;
    hit4 = 0;
    for (int i = 0; i < 200 && !hit4; i++) begin
      @(posedge clk);
      if (m_busy && !m_wr && m_k == 4) hit4 = 1;
    end
    check("mid_beat4", 64'(hit4), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rvalid", 64'(dc_out_rvalid), 64'd0);
    check("mid_reqv",   64'(mem_req_valid), 64'd0);
    check("mid_rdata",  dc_out_rdata, 64'd0);
    dc_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = m_rd_cnt;
    do_req("post", 64'h1000, 1'b0, '0, 2'd0, 0, rd, lat);
    check("post_nrd", 64'(m_rd_cnt - r0), 64'd1);
    check("post_rdata", rd, 64'hAB00_0011);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits directly downstream of the MEM stage and serves its dc_* request/response interface.
- Cache misses and all stores go to a simple line-fill memory port on the other side.
- Read data is returned as the full aligned doubleword; the MEM stage shifts and extends it.

Parameters:
ADDR_WIDTH, 64, request/memory address width
DATA_WIDTH, 64, beat and doubleword width
NUM_SETS, 64, number of lines (power of 2)
LINE_BYTES, 64, line size; LINE_BEATS = LINE_BYTES*8/DATA_WIDTH = 8

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dc_en  in  1  request present
dc_in_addr  in  ADDR_WIDTH  byte address
dc_write_en  in  1  1=store, 0=load
dc_in_wdata  in  64  store value, right-justified
dc_in_wlen  in  2  log2(bytes) of the store
dc_out_rdata  out  64  aligned doubleword containing addr
dc_out_rvalid  out  1  load complete
dc_out_write_done  out  1  store complete
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=single-beat write, 0=line read
mem_req_addr  out  ADDR_WIDTH  line-aligned for reads; doubleword-aligned for writes
mem_req_wdata  out  64  lane-shifted store data
mem_req_wstrb  out  8  byte enables
mem_resp_valid  in  1  read beat or write ack; no backpressure
mem_resp_data  in  64  read beat, ascending order from beat 0
mem_resp_last  in  1  final beat; set on the write ack

Behaviour:
- Reset values: all valid bits 0, FSM=IDLE, all outputs 0.
- Address split: offset=log2(LINE_BYTES), index=log2(NUM_SETS), tag=remaining upper bits.
- FSM states: IDLE, LOOKUP, FILL_REQ, FILL, WR_REQ, WR_ACK, RESP.
- IDLE: if dc_en, latch {addr, write_en, wdata, wlen} -> LOOKUP.
- LOOKUP, load hit: rdata register <- line doubleword -> RESP. Hit latency: rvalid high 2 cycles after the first dc_en cycle.
- LOOKUP, load miss -> FILL_REQ.
- LOOKUP, store: if hit, merge bytes into the line (same edge) -> WR_REQ. A store miss does not allocate.
- FILL_REQ: mem_req_valid=1, write=0, addr line-aligned. Hold until mem_req_ready -> FILL.
- FILL: on each mem_resp_valid, write the beat at beat counter, then increment the counter.
  - Capture the requested doubleword into the rdata register.
  - On mem_resp_last: set valid and tag -> RESP.
- WR_REQ: mem_req_valid=1, write=1.
  - wstrb = ((1<<(1<<wlen))-1) << addr[2:0].
  - wdata = wdata << (addr[2:0]*8).
  - On mem_req_ready -> WR_ACK.
- WR_ACK: on mem_resp_valid -> RESP.
- RESP: rvalid (load) or write_done (store) high.
  - Outputs stay high while dc_en=1 and the live request equals the latched one, so a MEM-stage stall never re-issues.
  - If the request changes or dc_en drops, outputs deassert combinationally that cycle; next state is LOOKUP (new request latched) or IDLE.
- Back-to-back requests from an atomic (load then store to the same addr) are handled through the RESP->LOOKUP path. The store hit updates the just-filled line.
- Misaligned access (offset + bytes > 8): sim-only $error; truncate wstrb to 8 bits.
- rdata is held from RESP until the next fill or hit. It is don't-care when rvalid=0.
- Reset mid-operation: FSM -> IDLE, valid bits cleared, mem_req_valid dropped. The memory model must reset too; stray beats arriving in IDLE are ignored.
- mem_req_* stay stable while valid && !ready.

Optional Feature:
- DCACHE_STATS_EN: adds outputs stat_hits, stat_misses, stat_stores (64 bits each).
  - Each increments once per request, on leaving LOOKUP.
  - Counters saturate and reset to 0.
- Without the macro: the ports and counters are absent.

Decomposition:
- Shared package gets:
  - dcache_state_t enum.
  - Width-to-strobe function wstrb_from_wlen(wlen, off).
  - Constants DC_LINE_BEATS, DC_OFF_BITS, DC_IDX_BITS.
- One sub-module, dcache_array: tag/valid/data storage.
  - One read port (index, beat select) and a byte-masked write port.
  - Valid-clear on reset.

Test Plan:
- Cold load 0x1000:
  - one mem read request at addr 0x1000, 8 beats 0x11..0x88.
  - rvalid with rdata=beat0.
  - A following load of 0x1008 hits: rdata=beat1, rvalid 2 cycles after dc_en, no mem_req.
- Store byte 0xAB to 0x1003 (wlen=0) after fill:
  - mem write addr 0x1000, wstrb=0x08, wdata=0xAB<<24.
  - A following load of 0x1000 returns the byte 0xAB in lane 3.
- Store word to uncached 0x3004: mem write with wstrb=0xF0; a following load 0x3000 misses (no allocate).
- Conflict: load 0x1000, then 0x2000 (same index at NUM_SETS=64), then 0x1000 -> three fills.
- Held request: dc_en and addr held 5 cycles past rvalid -> exactly one mem transaction, rvalid high all 5 cycles.
- Reset asserted at beat 4 of a fill -> all outputs 0 immediately; a following load 0x1000 misses and refills.
